// File: rtl/fp_result_skid.sv
// Two-entry skid buffer draining IEEE-754 results with head-word classification.
// Optional FP_SKID_CANON_NAN_EN: replace captured NaNs with the canonical quiet NaN.
module fp_result_skid #(
   parameter int EXP_BITS  = 8,
   parameter int MAN_BITS  = 23,
   parameter int WORD_SIZE = 1 + EXP_BITS + MAN_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] out_data,
   input  logic                 out_ready,
   output logic                 out_is_nan,
   output logic                 out_is_inf,
   output logic                 out_is_zero,
   output logic [1:0]           occupancy
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] head_q, head_d;
   logic [WORD_SIZE-1:0] skid_q, skid_d;
   logic                 in_ready_q, in_ready_d;
   logic                 in_fire, out_fire;
   logic [WORD_SIZE-1:0] cap_word;
   logic [EXP_BITS-1:0]  head_exp;
   logic [MAN_BITS-1:0]  head_man;

`ifdef FP_SKID_CANON_NAN_EN
   logic                 in_nan;
   assign in_nan = (&in_data[WORD_SIZE-2 -: EXP_BITS])
                 & (|in_data[MAN_BITS-1:0]);
   assign cap_word = in_nan
      ? {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}}
      : in_data;
`else
   assign cap_word = in_data;
`endif

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      skid_d     = skid_q;
      in_ready_d = in_ready_q;
      unique case (state_q)
         S_EMPTY: begin
            if (in_fire) begin
               head_d  = cap_word;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (in_fire && out_fire) begin
               head_d = cap_word;
            end else if (in_fire) begin
               skid_d     = cap_word;
               state_d    = S_TWO;
               in_ready_d = 1'b0;
            end else if (out_fire) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            // skid is older than anything upstream, so it moves to head
            if (out_fire) begin
               head_d     = skid_q;
               state_d    = S_ONE;
               in_ready_d = 1'b1;
            end
         end
         default: begin
            state_d    = S_EMPTY;
            in_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         head_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign head_exp  = head_q[WORD_SIZE-2 -: EXP_BITS];
   assign head_man  = head_q[MAN_BITS-1:0];

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != S_EMPTY);
   assign out_data    = head_q;
   assign occupancy   = state_q;
   assign out_is_nan  = out_valid & (&head_exp) & (|head_man);
   assign out_is_inf  = out_valid & (&head_exp) & ~(|head_man);
   assign out_is_zero = out_valid & ~(|head_exp) & ~(|head_man);

endmodule

// File: tb/tb_fp_result_skid.sv
// Bench for fp_result_skid: queue model checked every cycle plus directed literals.
// Define FP_SKID_CANON_NAN_EN for both bench and RTL to test the canonical-NaN build.
module tb_fp_result_skid;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        out_is_nan;
   logic        out_is_inf;
   logic        out_is_zero;
   logic [1:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mq[$];

   fp_result_skid dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .out_is_nan  (out_is_nan),
      .out_is_inf  (out_is_inf),
      .out_is_zero (out_is_zero),
      .occupancy   (occupancy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] stored(input logic [31:0] w);
      logic nan;
      nan = (w[30:23] == 8'hFF) && (w[22:0] != 0);
`ifdef FP_SKID_CANON_NAN_EN
      if (nan) return 32'h7FC0_0000;
`endif
      if (nan) return w;
      return w;
   endfunction

   // FIFO of capacity two: accept when not full, drain when non-empty
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
      end else begin
         bit acc, drn;
         acc = in_valid && (mq.size() < 2);
         drn = out_ready && (mq.size() > 0);
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back(stored(in_data));
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         logic        v;
         logic [31:0] h;
         v = (mq.size() > 0);
         h = v ? mq[0] : 32'h0;
         chk("m_valid", {31'b0, out_valid}, {31'b0, v});
         chk("m_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
         chk("m_occ", {30'b0, occupancy}, mq.size());
         if (v) chk("m_data", out_data, h);
         chk("m_nan", {31'b0, out_is_nan},
             {31'b0, v && h[30:23] == 8'hFF && h[22:0] != 0});
         chk("m_inf", {31'b0, out_is_inf},
             {31'b0, v && h[30:23] == 8'hFF && h[22:0] == 0});
         chk("m_zero", {31'b0, out_is_zero},
             {31'b0, v && h[30:0] == 0});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] w);
      in_valid = 1'b1;
      in_data  = w;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = 32'h0;
   endtask

   initial begin
      logic [31:0] nan_exp;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h1234_5678;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_occ", {30'b0, occupancy}, 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_zero", {31'b0, out_is_zero}, 32'h0);
      rst = 1'b0;
      idle();
      step();
      step();
      chk("idle_in_ready", {31'b0, in_ready}, 32'h1);
      chk("idle_occ", {30'b0, occupancy}, 32'h0);

      // streaming
      out_ready = 1'b1;
      put(32'h3F80_0000); step();
      chk("str0", out_data, 32'h3F80_0000);
      chk("str0_occ", {30'b0, occupancy}, 32'h1);
      put(32'h4000_0000); step();
      chk("str1", out_data, 32'h4000_0000);
      chk("str1_occ", {30'b0, occupancy}, 32'h1);
      put(32'h4040_0000); step();
      chk("str2", out_data, 32'h4040_0000);
      idle(); step();
      chk("str_empty", {30'b0, occupancy}, 32'h0);

      // backpressure and full+simultaneous
      out_ready = 1'b0;
      put(32'h3F80_0000); step();
      put(32'h4000_0000); step();
      chk("bp_occ", {30'b0, occupancy}, 32'h2);
      chk("bp_ready", {31'b0, in_ready}, 32'h0);
      put(32'h4040_0000); step();
      chk("bp_hold", out_data, 32'h3F80_0000);
      chk("bp_hold_occ", {30'b0, occupancy}, 32'h2);
      out_ready = 1'b1; step();
      chk("bp_drain", out_data, 32'h4000_0000);
      chk("bp_drain_occ", {30'b0, occupancy}, 32'h1);
      chk("bp_ready2", {31'b0, in_ready}, 32'h1);
      step();
      chk("bp_third", out_data, 32'h4040_0000);
      chk("bp_third_occ", {30'b0, occupancy}, 32'h1);
      idle(); step();

      // ONE with simultaneous in and out
      out_ready = 1'b0;
      put(32'h3F80_0000); step();
      put(32'hC000_0000); out_ready = 1'b1; step();
      chk("one_both", out_data, 32'hC000_0000);
      chk("one_both_occ", {30'b0, occupancy}, 32'h1);
      idle(); step();
      chk("one_drain_occ", {30'b0, occupancy}, 32'h0);
      step();
      chk("empty_ready_occ", {30'b0, occupancy}, 32'h0);

      // flags
      put(32'h7F80_0000); step();
      chk("f_inf", {29'b0, out_is_inf, out_is_nan, out_is_zero}, 32'h4);
      put(32'hFF80_0001); step();
      chk("f_nan", {29'b0, out_is_inf, out_is_nan, out_is_zero}, 32'h2);
      put(32'h8000_0000); step();
      chk("f_zero", {29'b0, out_is_inf, out_is_nan, out_is_zero}, 32'h1);
      put(32'h0000_0001); step();
      chk("f_none", {29'b0, out_is_inf, out_is_nan, out_is_zero}, 32'h0);
      put(32'h7F80_0001); step();
`ifdef FP_SKID_CANON_NAN_EN
      nan_exp = 32'h7FC0_0000;
`else
      nan_exp = 32'h7F80_0001;
`endif
      chk("f_nan_word", out_data, nan_exp);
      chk("f_nan_flag", {31'b0, out_is_nan}, 32'h1);
      idle(); step();

      // async reset mid-cycle while full
      out_ready = 1'b0;
      put(32'h1111_1111); step();
      put(32'h2222_2222); step();
      idle();
      chk("ar_pre_occ", {30'b0, occupancy}, 32'h2);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_occ", {30'b0, occupancy}, 32'h0);
      chk("ar_valid", {31'b0, out_valid}, 32'h0);
      chk("ar_ready", {31'b0, in_ready}, 32'h1);
      chk("ar_data", out_data, 32'h0);
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      put(32'h3333_3333); step();
      chk("ar_first", out_data, 32'h3333_3333);
      idle(); step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
